// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that feeds one shared four-function
// ALU from two requesters and returns each result, tagged with the ID of the
// requester that issued it, over a valid/ready channel. One operation is in
// flight at a time: IDLE (grant/accept) -> EXEC (capture) -> HOLD (return).
module alu_share_arbiter #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_A,
  input  logic [N-1:0]   req0_B,
  input  logic [1:0]     req0_Function,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_A,
  input  logic [N-1:0]   req1_B,
  input  logic [1:0]     req1_Function,
  output logic [N-1:0]   alu_A,
  output logic [N-1:0]   alu_B,
  output logic [1:0]     alu_Function,
  input  logic [2*N-1:0] alu_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res_data,
  output logic           res_id,
  output logic           busy,
  output logic [7:0]     ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t state_reg;
  // Requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic   last_reg;
  logic   grant0;
  logic   grant1;
  logic   idle;

  // Round-robin grant: a lone requester always wins, a tie goes to the one
  // that was not served last. Readies are masked outside IDLE and during Reset
  // so nothing can be accepted while an operation is in flight.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_reg);
    grant1     = req1_valid & ~grant0;
    idle       = (state_reg == IDLE);
    req0_ready = idle & ~Reset & grant0;
    req1_ready = idle & ~Reset & grant1;
    busy       = ~idle;
  end

  // Sequencer: latch the winner's bundle onto the ALU, capture the result one
  // cycle later, then hold it until the consumer takes it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_Function <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_id       <= 1'b0;
      ops_done     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_ready) begin
            alu_A        <= req0_A;
            alu_B        <= req0_B;
            alu_Function <= req0_Function;
            res_id       <= 1'b0;
            last_reg     <= 1'b0;
            state_reg    <= EXEC;
          end else if (req1_ready) begin
            alu_A        <= req1_A;
            alu_B        <= req1_B;
            alu_Function <= req1_Function;
            res_id       <= 1'b1;
            last_reg     <= 1'b1;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          // alu_out has had a full cycle to settle from the alu_* registers.
          res_data  <= alu_out;
          res_valid <= 1'b1;
          state_reg <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + 8'd1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencing front end for the shared N-bit four-function ALU (add, OR-reduce, AND-reduce, concatenate; 2N-bit result). Two requesters present operand/function bundles with valid/ready handshakes; the block round-robin arbitrates, registers the winner's operands onto the ALU inputs, captures the 2N-bit ALU result, and returns it with the winner's ID over a valid/ready result channel. Sits between the board-level input logic (switch/key front ends) and the ALU instance. One operation is in flight at a time.

## Interface
- N, default 4, operand width; the ALU is instantiated with the same N.

- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_A, req0_B  input  N each  requester 0 operands.
- req0_Function  input  2  requester 0 ALU function code.
- req1_valid, req1_ready, req1_A, req1_B, req1_Function  same as requester 0, for requester 1.
- alu_A, alu_B  output  N each  registered operands to ALU.
- alu_Function  output  2  registered function to ALU.
- alu_out  input  2N  combinational ALU result.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  2N  captured ALU result.
- res_id  output  1  requester that issued the result.
- busy  output  1  high in EXEC or HOLD.
- ops_done  output  8  completed-operation count.

## Operation
- States: IDLE, EXEC, HOLD.
- Grant is combinational and evaluated in IDLE only:
  - Only one reqX_valid high: that requester wins.
  - Both high: the requester that was **not** granted last wins.
  - `last` pointer resets to 1, so requester 0 wins the first tie.
- reqX_ready is high only in IDLE and only for the winner. The loser's ready stays 0.
- Accept occurs on reqX_valid & reqX_ready:
  - A/B/Function are latched into alu_A/alu_B/alu_Function.
  - res_id and last are both set to X.
  - The FSM moves IDLE→EXEC.
- EXEC lasts exactly one cycle:
  - res_data <= alu_out.
  - res_valid <= 1.
  - The FSM moves EXEC→HOLD.
- HOLD:
  - res_valid, res_data and res_id are held stable until res_valid & res_ready.
  - On that handshake: res_valid <= 0, ops_done increments (8-bit wrap 255→0), and the FSM moves HOLD→IDLE.
- No accept is possible in EXEC or HOLD. Both readies are 0 there.
- Requester inputs are sampled only on the accept edge. They may change freely while ready is low.
- alu_* outputs keep their last operands after completion. They are not cleared.
- Function codes: 0 = A+B (zero-extended to 2N), 1 = |A or |B, 2 = &A and &B, 3 = {A,B}. The arbiter passes the code through unmodified.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, last = 1.
  - alu_A = 0, alu_B = 0, alu_Function = 0.
  - res_valid = 0, res_data = 0, res_id = 0.
  - ops_done = 0, busy = 0, both readies 0 during the Reset cycle.
- Latency from an accept at edge t:
  - alu_* are valid after t.
  - res_data is captured at t+1.
  - res_valid is high after t+1.
- Minimum issue interval is 3 cycles: accept, EXEC, and HOLD with res_ready = 1, then IDLE.
- res_ready may be high before res_valid. That has no effect outside HOLD.
- Reset asserted in any state returns the block to reset values on the next edge:
  - The in-flight result is discarded.
  - ops_done is not incremented.
- A requester whose valid drops before ready is not served. No request state is stored.
- alu_out must settle within one cycle of the alu_* registers. No multicycle path is allowed.

## Test plan
- Single op: req0 A=3, B=5, F=0; req1 idle → req0_ready for 1 cycle; 2 cycles later res_valid=1, res_data=8'h08, res_id=0; with res_ready=1, ops_done=1.
- Tie after reset: both valid continuously, req0 F=3 A=4'hA B=4'h5, req1 F=2 A=4'hF B=4'hF → first result 8'hA5 id 0, second 8'h01 id 1, third id 0 (alternation).
- Backpressure: result pending with res_ready=0 for 5 cycles → res_valid, res_data and res_id stable, busy=1, both readies 0; then res_ready=1 → IDLE next cycle.
- Function 1 with A=0, B=0 → res_data 8'h00; with A=4'h4, B=0 → 8'h01.
- Reset during HOLD: pulse Reset for 1 cycle → res_valid=0, res_data=0, ops_done unchanged from 0-reset value (0), req0_ready returns next IDLE cycle.
- Counter wrap: 256 back-to-back completed ops with res_ready tied high → ops_done reads 0 after the 256th, interval exactly 3 cycles per op.
